mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the data side of MIPS_Processor. It snoops the core's data-memory bus: ALU-computed address, rt store data, mem_write and mem_read. Stores to its register window push bytes into a small FIFO, and an 8N1 serializer drains the FIFO onto tx_o. Loads from the window return status combinationally in the same cycle, so a single-cycle lw sees it; the top muxes read_data_o over RAM data when hit_o=1.

---
 rtl/mmio_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h10010400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic        mem_write_i,
    input  logic        mem_read_i,
    output logic [31:0] read_data_o,
    output logic        hit_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]     DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            pop;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            overflow;

    logic            sel_data, sel_status;
    logic            full, empty;
    logic            push_req, push_ok, clr_ovf;
    logic            unused_data_bits;

    assign sel_data   = (address_i == BASE_ADDR);
    assign sel_status = (address_i == BASE_ADDR + 32'd4);
    assign hit_o      = (sel_data | sel_status) & (mem_read_i | mem_write_i);

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    // A pop on the same edge frees a slot, so a full FIFO can still take a byte.
    assign push_req = sel_data & mem_write_i;
    assign push_ok  = push_req & (~full | pop);
    assign clr_ovf  = sel_status & mem_write_i & write_data_i[0];

    assign unused_data_bits = ^write_data_i[31:8];

    assign tx_o   = tx_q;
    assign busy_o = ~empty | (state_q != S_IDLE);

    // Status readback, valid in the same cycle as the load.
    always_comb begin
        read_data_o = '0;
        if (mem_read_i && sel_status) begin
            read_data_o[0]   = full;
            read_data_o[1]   = empty;
            read_data_o[2]   = (state_q != S_IDLE);
            read_data_o[3]   = overflow;
            read_data_o[7:4] = 4'(count);
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= write_data_i[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serializer next-state: frame timing, FIFO pop and next tx level.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr];
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end
            end
            S_START: begin
                if (clk_cnt_q == LAST_CLK) begin
                    state_d   = S_DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == LAST_CLK) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == LAST_CLK) begin
                    clk_cnt_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Serializer registers; tx comes straight from a flop so it never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h10010400;
    localparam logic [31:0] STAT = 32'h10010404;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] read_data;
    logic        hit;
    logic        tx;
    logic        busy;

    int checks = 0;
    int passed = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address_i   (address),
        .write_data_i(write_data),
        .mem_write_i (mem_write),
        .mem_read_i  (mem_read),
        .read_data_o (read_data),
        .hit_o       (hit),
        .tx_o        (tx),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_bus();
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_bus();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        address    = a;
        write_data = d;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        address = STAT; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h2) $display("FAIL reset_status: got %h want 00000002", read_data); else passed++;
        checks++; if (hit !== 1'b1) $display("FAIL reset_status_hit: got %b want 1", hit); else passed++;
        idle_bus();
    endtask

    task automatic test_decode();
        do_reset();
        address = BASE; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h0) $display("FAIL txdata_read: got %h want 00000000", read_data); else passed++;
        checks++; if (hit !== 1'b1) $display("FAIL txdata_hit: got %b want 1", hit); else passed++;
        address = 32'h10010000; #1;
        checks++; if (hit !== 1'b0) $display("FAIL ram_hit: got %b want 0", hit); else passed++;
        checks++; if (read_data !== 32'h0) $display("FAIL ram_read: got %h want 00000000", read_data); else passed++;
        address = BASE + 32'd8; #1;
        checks++; if (hit !== 1'b0) $display("FAIL base8_hit: got %b want 0", hit); else passed++;
        mem_read = 1'b0; address = BASE; #1;
        checks++; if (hit !== 1'b0) $display("FAIL no_strobe_hit: got %b want 0", hit); else passed++;
        store(BASE + 32'd1, 32'h55); #1;
        checks++; if (hit !== 1'b0) $display("FAIL misaligned_hit: got %b want 0", hit); else passed++;
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL misaligned_no_push: busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic       e;
        b = 8'hA5;
        do_reset();
        store(BASE, 32'h123456A5);
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 1) idle_bus();
            if (k < 2) e = 1'b1;
            else if (k < 6) e = 1'b0;
            else if (k < 38) e = b[(k - 6) / 4];
            else e = 1'b1;
            checks++; if (tx !== e) $display("FAIL single_tx cycle %0d: got %b want %b", k, tx, e); else passed++;
            if (k == 41) begin
                checks++; if (busy !== 1'b1) $display("FAIL single_busy_stop: got %b want 1", busy); else passed++;
            end
            if (k == 42) begin
                checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic       e;
        int         pos;
        do_reset();
        store(BASE, 32'h01);
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            if (k == 1) write_data = 32'h02;
            if (k == 2) idle_bus();
            if (k < 2) begin
                e = 1'b1;
            end else begin
                pos = (k - 2) % 40;
                b   = ((k - 2) / 40 == 0) ? 8'h01 : 8'h02;
                if (pos < 4) e = 1'b0;
                else if (pos < 36) e = b[(pos - 4) / 4];
                else e = 1'b1;
            end
            if (k <= 81) begin
                checks++; if (tx !== e) $display("FAIL b2b_tx cycle %0d: got %b want %b", k, tx, e); else passed++;
            end
            if (k == 81) begin
                checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_last: got %b want 1", busy); else passed++;
            end
            if (k == 82) begin
                checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy); else passed++;
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            store(BASE, 32'h10 + i);
            @(negedge clk);
        end
        idle_bus();
        address = STAT; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h45) $display("FAIL five_stores_status: got %h want 00000045", read_data); else passed++;
        store(BASE, 32'h99);
        @(negedge clk);
        idle_bus();
        address = STAT; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h4D) $display("FAIL overflow_status: got %h want 0000004d", read_data); else passed++;
        idle_bus();
    endtask

    task automatic test_status_clear();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            store(BASE, 32'h20 + i);
            @(negedge clk);
        end
        idle_bus();
        address = STAT; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h4D) $display("FAIL clr_pre_status: got %h want 0000004d", read_data); else passed++;
        store(STAT, 32'hFFFFFFFE);
        @(negedge clk);
        idle_bus();
        address = STAT; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h4D) $display("FAIL clr_bit0_zero: got %h want 0000004d", read_data); else passed++;
        mem_write = 1'b1; write_data = 32'h1; #1;
        checks++; if (read_data !== 32'h4D) $display("FAIL clr_same_cycle_read: got %h want 0000004d", read_data); else passed++;
        checks++; if (hit !== 1'b1) $display("FAIL clr_rw_hit: got %b want 1", hit); else passed++;
        @(negedge clk);
        idle_bus();
        address = STAT; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h45) $display("FAIL clr_after: got %h want 00000045", read_data); else passed++;
        idle_bus();
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        do_reset();
        store(BASE, 32'h00);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 1) write_data = 32'h55;
            if (k == 2) write_data = 32'hAA;
            if (k == 3) idle_bus();
        end
        checks++; if (tx !== 1'b0) $display("FAIL mid_data_bit3_tx: got %b want 0", tx); else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (tx !== 1'b1) $display("FAIL mid_reset_tx: got %b want 1", tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passed++;
        address = STAT; mem_read = 1'b1; #1;
        checks++; if (read_data !== 32'h2) $display("FAIL mid_reset_status: got %h want 00000002", read_data); else passed++;
        idle_bus();
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL mid_reset_no_frames: bad cycles %0d want 0", bad); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_decode();
        test_single();
        test_back_to_back();
        test_overflow();
        test_status_clear();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
